// File: rtl/servo_pkg.sv
// Shared constants and helpers for the servo PWM bank: divider and counter
// sizing, the power-on centre duty, and the slew-limited step toward a target.
package servo_pkg;

  // Widest supported duty word (16 bits) plus one bit of headroom.
  localparam int STEP_W = 17;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return (clk_hz / tick_hz < 1) ? 1 : clk_hz / tick_hz;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int centre_duty(input int duty_w);
    return 1 << (duty_w - 1);
  endfunction

  // A max_step of zero means the active duty jumps straight to the target.
  function automatic logic [STEP_W-1:0] step_toward(input logic [STEP_W-1:0] cur,
                                                    input logic [STEP_W-1:0] tgt,
                                                    input logic [STEP_W-1:0] max_step);
    logic [STEP_W-1:0] diff;
    if (max_step == '0) return tgt;
    diff = (tgt > cur) ? tgt - cur : cur - tgt;
    if (diff > max_step) diff = max_step;
    return (tgt > cur) ? cur + diff : cur - diff;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Tick divider and PWM frame counter; boundary marks the last tick of a frame.
module servo_frame_timer import servo_pkg::*; #(
  parameter int DIV         = 390,
  parameter int FRAME_TICKS = 2560,
  parameter int FW          = cnt_width(FRAME_TICKS)
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic [FW-1:0] fcnt,
  output logic          tick,
  output logic          boundary
);

  localparam int DVW = cnt_width(DIV);

  logic [DVW-1:0] div_cnt;

  assign tick     = (div_cnt == DVW'(DIV - 1));
  assign boundary = tick && (fcnt == FW'(FRAME_TICKS - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_cnt <= '0;
      fcnt    <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) fcnt <= boundary ? '0 : fcnt + 1'b1;
    end
  end

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM bank: double-buffered duties and enables that move to
// the active set only at frame boundaries, with optional per-frame slew limit.
module servo_pwm_bank import servo_pkg::*; #(
  parameter int CHANNELS    = 4,
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 128000,
  parameter int FRAME_TICKS = 2560,
  parameter int DUTY_W      = 8,
  parameter int MIN_TICKS   = 128,
  parameter int MAX_STEP    = 0,
  parameter int AW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DUTY_W-1:0]   wr_data,
  input  logic                en_we,
  input  logic [CHANNELS-1:0] en_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                frame_start,
  output logic                settled
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int FW  = cnt_width(FRAME_TICKS);
  localparam int CW  = ((FW > DUTY_W + 1) ? FW : DUTY_W + 1) + 1;
  localparam logic [DUTY_W-1:0] CENTRE = DUTY_W'(centre_duty(DUTY_W));

  generate
    if (MIN_TICKS + (1 << DUTY_W) - 1 >= FRAME_TICKS) begin : g_bad_frame
      $error("servo_pwm_bank: longest pulse does not fit inside a frame");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
      $error("servo_pwm_bank: CHANNELS must be 1..16");
    end
    if (DUTY_W < 1 || DUTY_W > 16) begin : g_bad_duty_w
      $error("servo_pwm_bank: DUTY_W must be 1..16");
    end
  endgenerate

  logic [FW-1:0]       fcnt;
  logic                tick_unused;
  logic                boundary;
  logic [CHANNELS-1:0] shadow_en;
  logic [CHANNELS-1:0] active_en;
  logic [CHANNELS-1:0] same;

  servo_frame_timer #(
    .DIV         (DIV),
    .FRAME_TICKS (FRAME_TICKS),
    .FW          (FW)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .fcnt     (fcnt),
    .tick     (tick_unused),
    .boundary (boundary)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shadow_en   <= '0;
      active_en   <= '0;
      frame_start <= 1'b0;
      settled     <= 1'b1;
    end else begin
      if (boundary) active_en <= shadow_en;
      if (en_we) shadow_en <= en_data;
      frame_start <= boundary;
      settled     <= &same;
    end
  end

  // The boundary update reads shadow before this edge's write lands, so a
  // write in the boundary cycle waits for the following frame.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DUTY_W-1:0] shadow;
    logic [DUTY_W-1:0] active;
    logic [DUTY_W-1:0] next_active;
    logic [CW-1:0]     limit;
    logic              pulse;

    assign next_active = DUTY_W'(step_toward(STEP_W'(active), STEP_W'(shadow),
                                             STEP_W'(MAX_STEP)));
    assign limit       = CW'(MIN_TICKS) + CW'(active);
    assign same[i]     = (active == shadow);
    assign pwm_out[i]  = pulse;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        shadow <= CENTRE;
        active <= CENTRE;
        pulse  <= 1'b0;
      end else begin
        if (boundary) active <= next_active;
        if (wr_en && wr_addr == AW'(i)) shadow <= wr_data;
        pulse <= active_en[i] && (CW'(fcnt) < limit);
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: two scaled-down instances (slew-limited 4-channel,
// unlimited 6-channel) checked every cycle against a frame-arithmetic model.
module tb_servo_pwm_bank;

  localparam int DIV       = 2;   // CLK_HZ=5 / TICK_HZ=2 truncates to 2
  localparam int FT        = 24;
  localparam int DW        = 4;
  localparam int MINT      = 4;
  localparam int CENTRE    = 8;
  localparam int STEP_A    = 3;
  localparam int FRAME_CLK = FT * DIV;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic          wr_en_a, en_we_a, wr_en_b, en_we_b;
  logic [1:0]    wr_addr_a;
  logic [2:0]    wr_addr_b;
  logic [DW-1:0] wr_data_a, wr_data_b;
  logic [3:0]    en_data_a;
  logic [5:0]    en_data_b;
  logic [3:0]    pwm_a;
  logic [5:0]    pwm_b;
  logic          fs_a, fs_b, settled_a, settled_b;

  servo_pwm_bank #(.CHANNELS(4), .CLK_HZ(5), .TICK_HZ(2), .FRAME_TICKS(FT), .DUTY_W(DW),
                   .MIN_TICKS(MINT), .MAX_STEP(STEP_A)) dut_a (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .en_we(en_we_a), .en_data(en_data_a), .pwm_out(pwm_a),
    .frame_start(fs_a), .settled(settled_a));

  servo_pwm_bank #(.CHANNELS(6), .CLK_HZ(5), .TICK_HZ(2), .FRAME_TICKS(FT), .DUTY_W(DW),
                   .MIN_TICKS(MINT), .MAX_STEP(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .en_we(en_we_b), .en_data(en_data_b), .pwm_out(pwm_b),
    .frame_start(fs_b), .settled(settled_b));

  int vectors = 0;
  int miscompares = 0;

  // Model state: per DUT, per channel; position in the frame is derived from
  // the number of clock edges since reset released.
  int          m_shadow [2][16];
  int          m_active [2][16];
  int          m_sen    [2][16];
  int          m_aen    [2][16];
  int          m_k;
  logic [15:0] e_pwm [2];
  logic        e_set [2];
  logic        e_fs;

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 6;
  endfunction

  function automatic int mstep(input int d);
    return (d == 0) ? STEP_A : 0;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic model_edge();
    int  fc;
    bit  bnd;
    int  diff;
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 16; i++) begin
          m_shadow[d][i] = CENTRE; m_active[d][i] = CENTRE;
          m_sen[d][i] = 0;         m_aen[d][i] = 0;
        end
        e_pwm[d] = '0;
        e_set[d] = 1'b1;
      end
      e_fs = 1'b0;
      m_k  = 0;
      return;
    end
    fc  = (m_k / DIV) % FT;
    bnd = ((m_k % DIV) == DIV - 1) && (fc == FT - 1);
    for (int d = 0; d < 2; d++) begin
      e_pwm[d] = '0;
      e_set[d] = 1'b1;
      for (int i = 0; i < nch(d); i++) begin
        e_pwm[d][i] = (m_aen[d][i] != 0) && (fc < MINT + m_active[d][i]);
        if (m_active[d][i] != m_shadow[d][i]) e_set[d] = 1'b0;
      end
      if (bnd) begin
        for (int i = 0; i < nch(d); i++) begin
          m_aen[d][i] = m_sen[d][i];
          diff = m_shadow[d][i] - m_active[d][i];
          if (mstep(d) != 0 && diff > mstep(d))  diff = mstep(d);
          if (mstep(d) != 0 && diff < -mstep(d)) diff = -mstep(d);
          m_active[d][i] += diff;
        end
      end
    end
    e_fs = bnd;
    if (wr_en_a) m_shadow[0][wr_addr_a] = int'(wr_data_a);
    if (en_we_a) for (int i = 0; i < 4; i++) m_sen[0][i] = int'(en_data_a[i]);
    if (wr_en_b && wr_addr_b < 6) m_shadow[1][wr_addr_b] = int'(wr_data_b);
    if (en_we_b) for (int i = 0; i < 6; i++) m_sen[1][i] = int'(en_data_b[i]);
    m_k++;
  endtask

  task automatic check_output();
    check("pwm_a", int'(pwm_a), int'(e_pwm[0][3:0]));
    check("pwm_b", int'(pwm_b), int'(e_pwm[1][5:0]));
    check("frame_start_a", int'(fs_a), int'(e_fs));
    check("frame_start_b", int'(fs_b), int'(e_fs));
    check("settled_a", int'(settled_a), int'(e_set[0]));
    check("settled_b", int'(settled_b), int'(e_set[1]));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_output();
  endtask

  task automatic apply_stimulus_idle();
    wr_en_a = 1'b0; en_we_a = 1'b0; wr_en_b = 1'b0; en_we_b = 1'b0;
  endtask

  task automatic sync_frame();
    int n;
    n = 0;
    do begin step(); n++; end while (!fs_a && n < 2 * FRAME_CLK);
    check("sync_frame", int'(fs_a), 1);
  endtask

  // Runs exactly one frame from a boundary, counting high cycles of one
  // channel; optionally writes that channel's duty at cycle wr_at.
  task automatic frame_hi(input int d, input int ch, input int wr_at, input int data,
                          output int hi, output int mid_set);
    hi = 0;
    mid_set = 0;
    for (int n = 0; n < FRAME_CLK; n++) begin
      if (n == wr_at) begin
        if (d == 0) begin wr_en_a = 1'b1; wr_addr_a = ch[1:0]; wr_data_a = data[DW-1:0]; end
        else        begin wr_en_b = 1'b1; wr_addr_b = ch[2:0]; wr_data_b = data[DW-1:0]; end
      end
      step();
      wr_en_a = 1'b0;
      wr_en_b = 1'b0;
      hi += (d == 0) ? int'(pwm_a[ch]) : int'(pwm_b[ch]);
      if (n == FRAME_CLK / 2) mid_set = (d == 0) ? int'(settled_a) : int'(settled_b);
    end
    check("frame_align", int'(fs_a), 1);
  endtask

  typedef struct {
    int ch;
    int duty;
    int mask;
    int cur_ticks;
    int next_ticks;
  } vec_t;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl [4];
    int   hi, ms, n;
    int   up_w  [4] = '{12, 15, 18, 19};
    int   up_s  [4] = '{0, 0, 0, 1};
    int   dn_w  [6] = '{19, 16, 13, 10, 7, 4};
    int   dn_s  [6] = '{0, 0, 0, 0, 0, 1};

    tbl[0] = '{2, 0,  'h3F, 12, 4};
    tbl[1] = '{5, 15, 'h3F, 12, 19};
    tbl[2] = '{0, 3,  'h3E, 0,  0};
    tbl[3] = '{0, 10, 'h3F, 7,  14};

    reset_n = 1'b0;
    apply_stimulus_idle();
    wr_addr_a = '0; wr_addr_b = '0; wr_data_a = '0; wr_data_b = '0;
    en_data_a = '0; en_data_b = '0;
    repeat (2) step();
    check("reset pwm_a", int'(pwm_a), 0);
    check("reset frame_start", int'(fs_a), 0);
    check("reset settled_a", int'(settled_a), 1);
    reset_n = 1'b1;

    // All channels enabled at centre duty: 12-tick pulses, 48-clock frames.
    en_we_a = 1'b1; en_data_a = 4'hF; en_we_b = 1'b1; en_data_b = 6'h3F;
    step();
    apply_stimulus_idle();
    sync_frame();
    for (int ch = 0; ch < 4; ch++) begin
      frame_hi(0, ch, -1, 0, hi, ms);
      check($sformatf("centre width ch%0d", ch), hi, (MINT + CENTRE) * DIV);
      check("centre settled", ms, 1);
    end
    n = 0;
    do begin step(); n++; end while (!fs_a && n < 2 * FRAME_CLK);
    check("frame period", n, FRAME_CLK);

    // Table: mid-frame duty writes on the unlimited bank.
    for (int v = 0; v < 4; v++) begin
      en_we_b = 1'b1; en_data_b = tbl[v].mask[5:0];
      step();
      apply_stimulus_idle();
      sync_frame();
      frame_hi(1, tbl[v].ch, 10, tbl[v].duty, hi, ms);
      check($sformatf("tbl%0d current width", v), hi, tbl[v].cur_ticks * DIV);
      check($sformatf("tbl%0d settled mid", v), ms, 0);
      frame_hi(1, tbl[v].ch, -1, 0, hi, ms);
      check($sformatf("tbl%0d next width", v), hi, tbl[v].next_ticks * DIV);
    end

    // Slew-limited bank ramps up then down by 3 per frame.
    for (int f = 0; f < 4; f++) begin
      frame_hi(0, 0, (f == 0) ? 10 : -1, 15, hi, ms);
      check($sformatf("slew up f%0d", f), hi, up_w[f] * DIV);
      check($sformatf("slew up settled f%0d", f), ms, up_s[f]);
    end
    for (int f = 0; f < 6; f++) begin
      frame_hi(0, 0, (f == 0) ? 10 : -1, 0, hi, ms);
      check($sformatf("slew down f%0d", f), hi, dn_w[f] * DIV);
      check($sformatf("slew down settled f%0d", f), ms, dn_s[f]);
    end

    // Write landing on the boundary edge itself waits one more frame.
    frame_hi(1, 1, FRAME_CLK - 1, 13, hi, ms);
    check("bnd write frame0", hi, (MINT + CENTRE) * DIV);
    frame_hi(1, 1, -1, 0, hi, ms);
    check("bnd write frame1", hi, (MINT + CENTRE) * DIV);
    frame_hi(1, 1, -1, 0, hi, ms);
    check("bnd write frame2", hi, (MINT + 13) * DIV);

    // Disabling mid-pulse lets the pulse finish; the next frame is dark.
    hi = 0;
    for (int k = 0; k < FRAME_CLK; k++) begin
      if (k == 6) begin en_we_b = 1'b1; en_data_b = 6'h3D; end
      step();
      en_we_b = 1'b0;
      hi += int'(pwm_b[1]);
    end
    check("disable mid-pulse", hi, (MINT + 13) * DIV);
    frame_hi(1, 1, -1, 0, hi, ms);
    check("disabled frame", hi, 0);

    // Out-of-range address on the 6-channel bank is ignored.
    wr_en_b = 1'b1; wr_addr_b = 3'd7; wr_data_b = '0;
    step();
    apply_stimulus_idle();
    repeat (3) begin
      step();
      check("addr7 settled", int'(settled_b), 1);
    end

    // Random traffic against the model.
    for (int k = 0; k < 1200; k++) begin
      wr_en_a   = ($urandom_range(0, 5) == 0);
      wr_addr_a = 2'($urandom_range(0, 3));
      wr_data_a = DW'($urandom);
      en_we_a   = ($urandom_range(0, 40) == 0);
      en_data_a = 4'($urandom);
      wr_en_b   = ($urandom_range(0, 5) == 0);
      wr_addr_b = 3'($urandom_range(0, 7));
      wr_data_b = DW'($urandom);
      en_we_b   = ($urandom_range(0, 40) == 0);
      en_data_b = 6'($urandom);
      step();
    end
    apply_stimulus_idle();

    // Reset in the middle of a pulse.
    en_we_a = 1'b1; en_data_a = 4'hF; en_we_b = 1'b1; en_data_b = 6'h3F;
    step();
    apply_stimulus_idle();
    sync_frame();
    repeat (6) step();
    reset_n = 1'b0;
    step();
    check("reset mid-pulse pwm_a", int'(pwm_a), 0);
    check("reset mid-pulse pwm_b", int'(pwm_b), 0);
    reset_n = 1'b1;
    n = 0;
    hi = 0;
    do begin
      step();
      n++;
      hi += int'(pwm_a != '0) + int'(pwm_b != '0);
    end while (!fs_a && n < 2 * FRAME_CLK);
    check("post-reset first boundary", n, FRAME_CLK);
    check("post-reset outputs low", hi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
